cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single reorder-buffer result write port among several execution units (ALU reservation stations, load/store buffer, branch unit). Each requester gets a one-entry holding slot. Every cycle the arbiter grants one occupied slot and drives a registered result bus into the reorder buffer's ready/rob_id/value write inputs. It sits between the execution units and the reorder buffer, and is flushed by the reorder buffer's `clear`.

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_rr_pick.sv | 33 +++
 rtl/cdb_arbiter.sv | 86 ++++++++
 tb/tb_cdb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: requester index defines,
// picker index width and pointer wrap helper.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif
`ifndef CDB_REQ_ALU
`define CDB_REQ_ALU 0
`endif
`ifndef CDB_REQ_LSB
`define CDB_REQ_LSB 1
`endif
`ifndef CDB_REQ_BR
`define CDB_REQ_BR 2
`endif

package cdb_arbiter_pkg;
   localparam int IDX_W = 3;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
      return (int'(idx) == n - 1) ? {IDX_W{1'b0}} : idx + 3'd1;
   endfunction
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_occ at or above i_ptr,
// wrapping modulo N. Also usable for reservation-station issue select.
module rr_pick
   import cdb_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     i_occ,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Walk slots in rotated order; the first occupied one wins.
   always_comb begin
      int  j;
      logic w_hit;
      o_gnt = {N{1'b0}};
      o_idx = {IDX_W{1'b0}};
      o_any = 1'b0;
      j     = 0;
      w_hit = 1'b0;
      for (int k = 0; k < N; k++) begin
         j        = (int'(i_ptr) + k) % N;
         w_hit    = !o_any && i_occ[j];
         o_gnt[j] = w_hit;
         o_idx    = w_hit ? IDX_W'(j) : o_idx;
         o_any    = o_any | w_hit;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the reorder-buffer result write port among
// execution units, with a one-entry holding slot per requester.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ROB_W   = `ROB_WIDTH_BIT
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rdy_in,
   input  logic                     clear,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*ROB_W-1:0] req_rob_id,
   input  logic [NUM_REQ*32-1:0]    req_value,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     cdb_valid,
   output logic [ROB_W-1:0]         cdb_rob_id,
   output logic [31:0]              cdb_value,
   output logic [2:0]               grant_id
);

   logic [NUM_REQ-1:0] r_occ;
   logic [ROB_W-1:0]   r_slot_id  [NUM_REQ];
   logic [31:0]        r_slot_val [NUM_REQ];
   logic [IDX_W-1:0]   r_ptr;

   logic [NUM_REQ-1:0] w_gnt;
   logic [IDX_W-1:0]   w_idx;
   logic               w_any;
   logic [NUM_REQ-1:0] w_take;

   rr_pick #(
      .N(NUM_REQ)
   ) u_pick (
      .i_occ(r_occ),
      .i_ptr(r_ptr),
      .o_gnt(w_gnt),
      .o_idx(w_idx),
      .o_any(w_any)
   );

   // A slot being drained this edge may be refilled on the same edge.
   assign req_ready = (rdy_in && !clear) ? (~r_occ | w_gnt) : {NUM_REQ{1'b0}};
   assign w_take    = req_valid & req_ready;

   // Slot capture, grant bookkeeping and the registered result bus.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_occ      <= {NUM_REQ{1'b0}};
         r_ptr      <= {IDX_W{1'b0}};
         cdb_valid  <= 1'b0;
         cdb_rob_id <= {ROB_W{1'b0}};
         cdb_value  <= 32'd0;
         grant_id   <= 3'd0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_slot_id[i]  <= {ROB_W{1'b0}};
            r_slot_val[i] <= 32'd0;
         end
      end else if (rdy_in) begin
         if (clear) begin
            r_occ     <= {NUM_REQ{1'b0}};
            r_ptr     <= {IDX_W{1'b0}};
            cdb_valid <= 1'b0;
         end else begin
            cdb_valid <= w_any;
            if (w_any) begin
               cdb_rob_id <= r_slot_id[w_idx];
               cdb_value  <= r_slot_val[w_idx];
               r_ptr      <= wrap_inc(w_idx, NUM_REQ);
               grant_id   <= w_idx;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
               if (w_take[i]) begin
                  r_occ[i]      <= 1'b1;
                  r_slot_id[i]  <= req_rob_id[i*ROB_W +: ROB_W];
                  r_slot_val[i] <= req_value[i*32 +: 32];
               end else if (w_gnt[i]) begin
                  r_occ[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a slot/queue-level reference model.
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int RW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, rdy, clr;
   logic [N-1:0]      v;
   logic [N*RW-1:0]   ids;
   logic [N*32-1:0]   vals;
   logic [N-1:0]      req_ready;
   logic              cdb_valid;
   logic [RW-1:0]     cdb_rob_id;
   logic [31:0]       cdb_value;
   logic [2:0]        grant_id;

   cdb_arbiter #(.NUM_REQ(N), .ROB_W(RW)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear(clr),
      .req_valid(v), .req_rob_id(ids), .req_value(vals),
      .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
      .cdb_value(cdb_value), .grant_id(grant_id)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference model: holding slots plus the bus contents
   bit            m_occ [N];
   logic [RW-1:0] m_id  [N];
   logic [31:0]   m_val [N];
   int            m_ptr;
   bit            m_cv;
   logic [RW-1:0] m_cid;
   logic [31:0]   m_cval;
   int            m_gid;

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         if (m_occ[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_occ[i] = 1'b0; m_id[i] = '0; m_val[i] = '0;
      end
      m_ptr = 0; m_cv = 1'b0; m_cid = '0; m_cval = '0; m_gid = 0;
   endtask

   task automatic model_edge();
      int g;
      bit rd [N];
      if (!rdy) return;
      if (clr) begin
         for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
         m_cv  = 1'b0;
         m_ptr = 0;
         return;
      end
      g = pick();
      for (int i = 0; i < N; i++) rd[i] = !m_occ[i] || (g == i);
      if (g >= 0) begin
         m_cv   = 1'b1;
         m_cid  = m_id[g];
         m_cval = m_val[g];
         m_gid  = g;
         m_ptr  = (g + 1) % N;
         m_occ[g] = 1'b0;
      end else begin
         m_cv = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (v[i] && rd[i]) begin
            m_occ[i] = 1'b1;
            m_id[i]  = ids[i*RW +: RW];
            m_val[i] = vals[i*32 +: 32];
         end
      end
   endtask

   task automatic compare_ready();
      logic [N-1:0] exp;
      int g;
      g = pick();
      for (int i = 0; i < N; i++) exp[i] = rdy && !clr && (!m_occ[i] || g == i);
      chk("req_ready", 64'(req_ready), 64'(exp));
   endtask

   task automatic compare_out();
      chk("cdb_valid", 64'(cdb_valid), 64'(m_cv));
      chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_cid));
      chk("cdb_value", 64'(cdb_value), 64'(m_cval));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
   endtask

   // one clock: check ready before the edge, advance model, check bus after
   task automatic tick();
      #1 compare_ready();
      @(posedge clk);
      model_edge();
      #1 compare_out();
   endtask

   task automatic set_req(input int i, input logic [RW-1:0] id, input logic [31:0] val);
      v[i] = 1'b1;
      ids[i*RW +: RW]  = id;
      vals[i*32 +: 32] = val;
   endtask

   task automatic idle_in();
      v = '0;
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; clr = 1'b0; v = '0; ids = '0; vals = '0;
      model_reset();
      #3;
      chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("rst_cdb_value", 64'(cdb_value), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", 64'(req_ready), 64'hF);
      chk("idle_rob_id", 64'(cdb_rob_id), 64'd0);
      tick();
      chk("idle_valid", 64'(cdb_valid), 64'd0);

      // contention: all four at once, bus order 1,2,3,4 then reload
      for (int i = 0; i < N; i++) set_req(i, RW'(i + 1), 32'h100 + 32'(i));
      tick();
      idle_in();
      tick(); chk("cont_1", 64'(cdb_rob_id), 64'd1);
      tick(); chk("cont_2", 64'(cdb_rob_id), 64'd2);
      set_req(0, 4'd9, 32'h900);
      set_req(3, 4'd10, 32'hA00);
      tick(); chk("cont_3", 64'(cdb_rob_id), 64'd3);
      idle_in();
      tick(); chk("cont_4_slot3", 64'(cdb_rob_id), 64'd4);
      chk("cont_4_gid", 64'(grant_id), 64'd3);
      tick(); chk("reload_slot0", 64'(cdb_rob_id), 64'd9);
      tick(); chk("cont_drained", 64'(cdb_valid), 64'd0);

      // single request from requester 2
      set_req(2, 4'd5, 32'hDEADBEEF);
      tick();
      idle_in();
      tick();
      chk("single_valid", 64'(cdb_valid), 64'd1);
      chk("single_id", 64'(cdb_rob_id), 64'd5);
      chk("single_val", 64'(cdb_value), 64'hDEADBEEF);
      tick();
      chk("single_done", 64'(cdb_valid), 64'd0);

      // streaming from requester 1
      for (int j = 0; j < 8; j++) begin
         set_req(1, RW'(j), 32'd100 + 32'(j));
         tick();
         if (j > 0) chk("stream_val", 64'(cdb_value), 64'd100 + 64'(j - 1));
      end
      idle_in();
      tick(); chk("stream_last", 64'(cdb_value), 64'd107);
      tick(); chk("stream_done", 64'(cdb_valid), 64'd0);

      // flush with slots 0 and 2 occupied
      set_req(0, 4'd1, 32'h11);
      set_req(2, 4'd2, 32'h22);
      tick();
      idle_in();
      clr = 1'b1;
      #1 chk("clear_ready", 64'(req_ready), 64'd0);
      tick();
      chk("clear_valid", 64'(cdb_valid), 64'd0);
      clr = 1'b0;
      tick();
      chk("clear_dropped", 64'(cdb_valid), 64'd0);
      set_req(1, 4'd11, 32'hB1);
      set_req(3, 4'd12, 32'hC3);
      tick();
      idle_in();
      tick(); chk("post_clear_ptr0", 64'(cdb_rob_id), 64'd11);
      tick(); chk("post_clear_2nd", 64'(cdb_rob_id), 64'd12);

      // pause with rob_id 7 on the bus
      set_req(0, 4'd7, 32'h77);
      set_req(1, 4'd8, 32'h88);
      tick();
      idle_in();
      tick(); chk("pause_pre", 64'(cdb_rob_id), 64'd7);
      rdy = 1'b0;
      set_req(2, 4'd13, 32'hDD);
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("pause_valid", 64'(cdb_valid), 64'd1);
         chk("pause_id", 64'(cdb_rob_id), 64'd7);
      end
      rdy = 1'b1;
      idle_in();
      tick(); chk("pause_resume", 64'(cdb_rob_id), 64'd8);
      tick(); chk("pause_nocapture", 64'(cdb_valid), 64'd0);

      // asynchronous reset mid-operation
      set_req(3, 4'd6, 32'h66);
      tick();
      idle_in();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_valid", 64'(cdb_valid), 64'd0);
      chk("async_rst_ready", 64'(req_ready), 64'hF);
      compare_out();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
